sa_output_deskew: RTL and testbench
===================================

Name: sa_output_deskew

Overview:
- Downstream stage of the systolic controller and array: consumes the staggered bottom-edge outputs of the array and writes realigned output rows to output memory.
- Column j of a given output row leaves the array j cycles after column 0. This block delays each column so the row is re-aligned, then buffers aligned rows in a small FIFO.
- Rows drain to the output memory write port with sequential addresses.
- Signals o_done once the programmed number of rows has been written.

Parameters:
- NUM_COLS, 4, number of array columns; number of data lanes per row
- DATA_WIDTH, 32, bits per column result
- FIFO_DEPTH, 4, aligned-row buffer depth; power of two, ≥2
- OUTPUT_MEM_WIDTH, 8, output memory address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle pulse; latches i_base_addr and i_num_rows
- i_base_addr  in  OUTPUT_MEM_WIDTH  first write address
- i_num_rows  in  OUTPUT_MEM_WIDTH  rows to write this job
- i_col_valid  in  NUM_COLS  per-column valid from array bottom edge
- i_col_data  in  NUM_COLS*DATA_WIDTH  per-column results; column j occupies bits [j*DATA_WIDTH +: DATA_WIDTH]
- i_mem_ready  in  1  output memory accepts a write this cycle
- w_output_en  out  1  write strobe
- w_output_addr  out  OUTPUT_MEM_WIDTH  write address
- w_output_data  out  NUM_COLS*DATA_WIDTH  aligned row
- o_busy  out  1  high in ACTIVE
- o_done  out  1  job complete; held until next accepted i_start
- o_overflow  out  1  sticky: row dropped because FIFO was full
- o_misalign  out  1  sticky: aligned valids were not all-equal
- o_fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy

Behaviour:
- Reset: all outputs 0, including o_done, both sticky flags and o_fifo_count. FIFO is empty, counters are 0, state is IDLE. Delay-line contents are cleared (valids 0).
- States: IDLE, ACTIVE, DONE.
  - IDLE or DONE, on i_start: latch base address and row count; clear rows_written, o_done, o_overflow and o_misalign; flush the FIFO and delay lines.
  - After that i_start: go to ACTIVE, or directly to DONE if i_num_rows == 0. In the zero-row case o_done rises on the following edge.
  - ACTIVE: i_start is ignored. Go to DONE on the edge where the write making rows_written == num_rows occurs.
  - DONE: o_done = 1 and o_busy = 0.
- Deskew: column j passes through (NUM_COLS-1-j) register stages for both data and valid. Column NUM_COLS-1 has zero delay.
- Alignment and push:
  - If the aligned valids are all 1 in ACTIVE, the aligned row is pushed into the FIFO at the clock edge.
  - If the aligned valids are mixed (some 1, some 0), no push occurs and o_misalign is set.
  - Valids are ignored outside ACTIVE, but delay lines still shift.
- Latency: if column 0 is valid in cycle t, column j must be valid in cycle t+j. The row is pushed at the end of cycle t+NUM_COLS-1, and the earliest write is in cycle t+NUM_COLS.
- Write, combinational from FIFO head:
  - w_output_en = ACTIVE & FIFO non-empty & i_mem_ready.
  - w_output_data = head row.
  - w_output_addr = base + rows_written, truncated to OUTPUT_MEM_WIDTH (address wraps at 2^OUTPUT_MEM_WIDTH).
  - On an edge with w_output_en high: pop the FIFO and increment rows_written.
  - When w_output_en is low, w_output_addr and w_output_data are don't-care.
- Push with FIFO full:
  - If a pop occurs in the same cycle, the push succeeds and the count is unchanged.
  - Otherwise the row is dropped and o_overflow is set. The array cannot be stalled.
- Extra valid rows arriving after rows_written reaches num_rows (in DONE) are ignored.
- o_fifo_count reflects post-edge occupancy.
- Asynchronous reset at any time (mid-row, mid-drain) returns to the reset state immediately. No partial write is issued after reset.

Test Plan:
- NUM_COLS=4: i_start with base=0x10, rows=3; three rows with col j valid at cycle t+j for t=5,6,7, col j data = 100*row+j; i_mem_ready=1 -> writes at cycles 9,10,11 to 0x10,0x11,0x12; data lanes {0,1,2,3},{100..103},{200..203}; o_done=1 from cycle 12.
- Same as the first case but i_mem_ready=0 for 6 cycles -> o_fifo_count reaches 3, no writes; on release, 3 back-to-back writes in order; o_overflow stays 0.
- FIFO_DEPTH=4, rows=6, i_mem_ready=0 throughout -> 4 rows buffered; 5th and 6th rows dropped; o_overflow=1; o_done stays 0.
- Column 2 valid one cycle late for row 0 -> o_misalign=1; row 0 not written; the next correctly skewed row is written to base+0.
- i_num_rows=0 with i_start -> o_busy never 1; o_done=1 two edges after start. Then base=0xFE, rows=3 -> addresses 0xFE, 0xFF, 0x00 (wrap).
- rst_n asserted while FIFO holds 2 rows -> all outputs 0 immediately, count 0. After release, a new job writes only new data.

Source files
------------

// File: rtl/sa_output_deskew.sv
// Realigns staggered bottom-edge column outputs of the systolic array into rows,
// buffers them in a small FIFO and writes them to output memory at sequential addresses.
// Latency: column 0 valid in cycle t -> row pushed at end of t+NUM_COLS-1, earliest write in t+NUM_COLS.
// Backpressure: i_mem_ready stalls the drain only; the array cannot be stalled, so a row
// arriving with the FIFO full (and no pop that cycle) is dropped and flagged in o_overflow.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_start, i_base_addr, i_num_rows job launch (ignored while ACTIVE)
//   i_col_valid, i_col_data         skewed per-column results from the array
//   i_mem_ready                     output memory can accept a write
//   w_output_en/addr/data           output memory write port (combinational from FIFO head)
//   o_busy, o_done                  job status
//   o_overflow, o_misalign          sticky error flags, cleared by an accepted i_start
//   o_fifo_count                    aligned-row FIFO occupancy
module sa_output_deskew #(
    parameter int NUM_COLS         = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int OUTPUT_MEM_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic [OUTPUT_MEM_WIDTH-1:0]      i_base_addr,
    input  logic [OUTPUT_MEM_WIDTH-1:0]      i_num_rows,
    input  logic [NUM_COLS-1:0]              i_col_valid,
    input  logic [NUM_COLS*DATA_WIDTH-1:0]   i_col_data,
    input  logic                             i_mem_ready,
    output logic                             w_output_en,
    output logic [OUTPUT_MEM_WIDTH-1:0]      w_output_addr,
    output logic [NUM_COLS*DATA_WIDTH-1:0]   w_output_data,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_overflow,
    output logic                             o_misalign,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_count
);

    localparam int ROW_W = NUM_COLS * DATA_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [OUTPUT_MEM_WIDTH-1:0] r_base;
    logic [OUTPUT_MEM_WIDTH-1:0] r_num_rows;
    logic [OUTPUT_MEM_WIDTH-1:0] r_rows_written;
    logic                        r_done;
    logic                        r_overflow;
    logic                        r_misalign;
    logic [ROW_W-1:0]            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            r_count;

    logic                        w_active;
    logic                        w_start_acc;
    logic [NUM_COLS-1:0]         w_al_vld;
    logic [ROW_W-1:0]            w_al_row;
    logic                        w_push_req;
    logic                        w_push;
    logic                        w_drop;
    logic                        w_mis;
    logic                        w_full;
    logic [OUTPUT_MEM_WIDTH-1:0] w_rows_inc;
    logic                        w_last_wr;

    assign w_active    = (r_state == S_ACTIVE);
    assign w_start_acc = i_start && !w_active;

    // Column j needs NUM_COLS-1-j stages so every lane lines up with the last column.
    for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
        localparam int D = NUM_COLS - 1 - gj;
        if (D == 0) begin : g_pass
            assign w_al_vld[gj] = i_col_valid[gj];
            assign w_al_row[gj*DATA_WIDTH +: DATA_WIDTH] = i_col_data[gj*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_dly
            logic [D-1:0]                 r_v;
            logic [D-1:0][DATA_WIDTH-1:0] r_d;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= '0;
                    r_d <= '0;
                end else if (w_start_acc) begin
                    r_v <= '0;
                    r_d <= '0;
                end else begin
                    r_v[0] <= i_col_valid[gj];
                    r_d[0] <= i_col_data[gj*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k < D; k++) begin
                        r_v[k] <= r_v[k-1];
                        r_d[k] <= r_d[k-1];
                    end
                end
            end
            assign w_al_vld[gj] = r_v[D-1];
            assign w_al_row[gj*DATA_WIDTH +: DATA_WIDTH] = r_d[D-1];
        end
    end

    assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_output_en   = w_active && (r_count != '0) && i_mem_ready;
    assign w_output_addr = r_base + r_rows_written;
    assign w_output_data = r_mem[r_rd_ptr];

    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign w_push_req = w_active && (&w_al_vld);
    assign w_push     = w_push_req && (!w_full || w_output_en);
    assign w_drop     = w_push_req && !w_push;
    assign w_mis      = w_active && (|w_al_vld) && !(&w_al_vld);

    assign w_rows_inc = r_rows_written + OUTPUT_MEM_WIDTH'(1);
    assign w_last_wr  = w_output_en && (w_rows_inc == r_num_rows);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) w_state_nxt = (i_num_rows == '0) ? S_DONE : S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_last_wr) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Job registers, status and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base         <= '0;
            r_num_rows     <= '0;
            r_rows_written <= '0;
            r_done         <= 1'b0;
            r_overflow     <= 1'b0;
            r_misalign     <= 1'b0;
        end else if (w_start_acc) begin
            r_base         <= i_base_addr;
            r_num_rows     <= i_num_rows;
            r_rows_written <= '0;
            r_done         <= 1'b0;
            r_overflow     <= 1'b0;
            r_misalign     <= 1'b0;
        end else begin
            if (w_output_en) r_rows_written <= w_rows_inc;
            // Final write raises done with the state change; a zero-row job
            // sits one cycle in DONE before done rises.
            if (w_last_wr || (r_state == S_DONE)) r_done <= 1'b1;
            if (w_drop) r_overflow <= 1'b1;
            if (w_mis)  r_misalign <= 1'b1;
        end
    end

    // Aligned-row FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_start_acc) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_al_row;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_output_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_output_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_busy       = w_active;
    assign o_done       = r_done;
    assign o_overflow   = r_overflow;
    assign o_misalign   = r_misalign;
    assign o_fifo_count = r_count;

endmodule

// File: tb/tb_sa_output_deskew.sv
// Directed bench for sa_output_deskew: each job is driven cycle by cycle from a row schedule
// (column 0 of row r at cycle 5+stride*r, column j j cycles later), outputs are recorded at
// the falling edge and compared against hand-derived per-cycle expectations.
module tb_sa_output_deskew;

    localparam int NC = 4;
    localparam int DW = 32;
    localparam int FD = 4;
    localparam int AW = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic [AW-1:0]    i_base_addr;
    logic [AW-1:0]    i_num_rows;
    logic [NC-1:0]    i_col_valid;
    logic [NC*DW-1:0] i_col_data;
    logic             i_mem_ready;
    logic             w_output_en;
    logic [AW-1:0]    w_output_addr;
    logic [NC*DW-1:0] w_output_data;
    logic             o_busy;
    logic             o_done;
    logic             o_overflow;
    logic             o_misalign;
    logic [2:0]       o_fifo_count;

    sa_output_deskew #(.NUM_COLS(NC), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .OUTPUT_MEM_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_rows(i_num_rows), .i_col_valid(i_col_valid), .i_col_data(i_col_data),
        .i_mem_ready(i_mem_ready), .w_output_en(w_output_en), .w_output_addr(w_output_addr),
        .w_output_data(w_output_data), .o_busy(o_busy), .o_done(o_done),
        .o_overflow(o_overflow), .o_misalign(o_misalign), .o_fifo_count(o_fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic             rec_en   [32];
    logic [AW-1:0]    rec_addr [32];
    logic [NC*DW-1:0] rec_data [32];
    logic [2:0]       rec_cnt  [32];
    logic             rec_busy [32];
    logic             rec_done [32];
    logic             rec_ovf  [32];
    logic             rec_mis  [32];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] row_val(input int dbase, input int r);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < NC; j++) v[j*DW +: DW] = 32'(dbase + 100*r + j);
        return v;
    endfunction

    // Drives one job starting at cycle 0; returns at posedge+1 after cycle ncyc-1.
    task automatic run_job(input int base, input int rows, input int nsend, input int stride,
                           input int late_col, input int dbase, input int rdy_lo,
                           input int rdy_hi, input int ncyc);
        int tj;
        for (int c = 0; c < ncyc; c++) begin
            i_start     = (c == 0);
            i_base_addr = AW'(base);
            i_num_rows  = AW'(rows);
            i_mem_ready = !(c >= rdy_lo && c <= rdy_hi);
            i_col_valid = '0;
            i_col_data  = '0;
            for (int r = 0; r < nsend; r++) begin
                for (int j = 0; j < NC; j++) begin
                    tj = 5 + stride*r + j + ((j == late_col && r == 0) ? 1 : 0);
                    if (c == tj) begin
                        i_col_valid[j]          = 1'b1;
                        i_col_data[j*DW +: DW]  = 32'(dbase + 100*r + j);
                    end
                end
            end
            @(negedge clk);
            rec_en[c]   = w_output_en;
            rec_addr[c] = w_output_addr;
            rec_data[c] = w_output_data;
            rec_cnt[c]  = o_fifo_count;
            rec_busy[c] = o_busy;
            rec_done[c] = o_done;
            rec_ovf[c]  = o_overflow;
            rec_mis[c]  = o_misalign;
            @(posedge clk);
            #1;
        end
        i_start     = 1'b0;
        i_col_valid = '0;
        i_col_data  = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},   128'(w_output_en),   128'(0));
        chk({tag, "_addr"}, 128'(w_output_addr), 128'(0));
        chk({tag, "_data"}, 128'(w_output_data), 128'(0));
        chk({tag, "_busy"}, 128'(o_busy),        128'(0));
        chk({tag, "_done"}, 128'(o_done),        128'(0));
        chk({tag, "_ovf"},  128'(o_overflow),    128'(0));
        chk({tag, "_mis"},  128'(o_misalign),    128'(0));
        chk({tag, "_cnt"},  128'(o_fifo_count),  128'(0));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_num_rows  = '0;
        i_col_valid = '0;
        i_col_data  = '0;
        i_mem_ready = 1'b1;
        #12;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Job 1: three rows, memory always ready -> writes at cycles 9..11.
        run_job(8'h10, 3, 3, 1, -1, 0, 1000, 0, 14);
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("j1_en_c%0d", c), 128'(rec_en[c]), 128'(c >= 9 && c <= 11));
            chk($sformatf("j1_cnt_c%0d", c), 128'(rec_cnt[c]), 128'((c >= 9 && c <= 11) ? 1 : 0));
            chk($sformatf("j1_busy_c%0d", c), 128'(rec_busy[c]), 128'(c >= 1 && c <= 11));
            chk($sformatf("j1_done_c%0d", c), 128'(rec_done[c]), 128'(c >= 12));
            if (c >= 9 && c <= 11) begin
                chk($sformatf("j1_addr_c%0d", c), 128'(rec_addr[c]), 128'(8'h10 + c - 9));
                chk($sformatf("j1_data_c%0d", c), rec_data[c], row_val(0, c - 9));
            end
        end

        // Job 2: memory stalled cycles 9..14 -> three rows buffered, drained at 15..17.
        run_job(8'h10, 3, 3, 1, -1, 0, 9, 14, 20);
        for (int c = 1; c < 20; c++) begin
            chk($sformatf("j2_en_c%0d", c), 128'(rec_en[c]), 128'(c >= 15 && c <= 17));
            chk($sformatf("j2_cnt_c%0d", c), 128'(rec_cnt[c]),
                128'(c < 9 ? 0 : c == 9 ? 1 : c == 10 ? 2 : c <= 15 ? 3 : c == 16 ? 2 : c == 17 ? 1 : 0));
            chk($sformatf("j2_done_c%0d", c), 128'(rec_done[c]), 128'(c >= 18));
            chk($sformatf("j2_ovf_c%0d", c), 128'(rec_ovf[c]), 128'(0));
            if (c >= 15 && c <= 17) begin
                chk($sformatf("j2_addr_c%0d", c), 128'(rec_addr[c]), 128'(8'h10 + c - 15));
                chk($sformatf("j2_data_c%0d", c), rec_data[c], row_val(0, c - 15));
            end
        end

        // Job 3: six rows, memory never ready -> four buffered, rows 5 and 6 dropped.
        run_job(8'h00, 6, 6, 1, -1, 0, 0, 1000, 16);
        for (int c = 1; c < 16; c++) begin
            chk($sformatf("j3_en_c%0d", c), 128'(rec_en[c]), 128'(0));
            chk($sformatf("j3_cnt_c%0d", c), 128'(rec_cnt[c]),
                128'(c < 9 ? 0 : c >= 12 ? 4 : c - 8));
            chk($sformatf("j3_ovf_c%0d", c), 128'(rec_ovf[c]), 128'(c >= 13));
            chk($sformatf("j3_done_c%0d", c), 128'(rec_done[c]), 128'(0));
            chk($sformatf("j3_busy_c%0d", c), 128'(rec_busy[c]), 128'(1));
        end
        do_reset();

        // Job 4: row 0 has column 2 one cycle late; row 1 (correctly skewed) goes to base+0.
        run_job(8'h40, 1, 2, 4, 2, 0, 1000, 0, 16);
        for (int c = 1; c < 16; c++) begin
            chk($sformatf("j4_mis_c%0d", c), 128'(rec_mis[c]), 128'(c >= 9));
            chk($sformatf("j4_en_c%0d", c), 128'(rec_en[c]), 128'(c == 13));
            chk($sformatf("j4_cnt_c%0d", c), 128'(rec_cnt[c]), 128'(c == 13 ? 1 : 0));
            chk($sformatf("j4_done_c%0d", c), 128'(rec_done[c]), 128'(c >= 14));
            if (c == 13) begin
                chk("j4_addr", 128'(rec_addr[c]), 128'(8'h40));
                chk("j4_data", rec_data[c], row_val(0, 1));
            end
        end

        // Job 5a: zero rows -> never busy, done two edges after start.
        run_job(8'h00, 0, 0, 1, -1, 0, 1000, 0, 4);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("j5a_busy_c%0d", c), 128'(rec_busy[c]), 128'(0));
            chk($sformatf("j5a_en_c%0d", c), 128'(rec_en[c]), 128'(0));
            if (c >= 1) chk($sformatf("j5a_done_c%0d", c), 128'(rec_done[c]), 128'(c >= 2));
        end

        // Job 5b: base 0xFE, three rows -> addresses wrap to 0x00.
        run_job(8'hFE, 3, 3, 1, -1, 1000, 1000, 0, 14);
        for (int c = 1; c < 14; c++) begin
            chk($sformatf("j5b_en_c%0d", c), 128'(rec_en[c]), 128'(c >= 9 && c <= 11));
            chk($sformatf("j5b_done_c%0d", c), 128'(rec_done[c]), 128'(c >= 12));
            if (c >= 9 && c <= 11) begin
                chk($sformatf("j5b_addr_c%0d", c), 128'(rec_addr[c]), 128'(8'((8'hFE + c - 9) & 8'hFF)));
                chk($sformatf("j5b_data_c%0d", c), rec_data[c], row_val(1000, c - 9));
            end
        end

        // Job 6: two rows buffered, then asynchronous reset mid-job.
        run_job(8'h20, 4, 2, 1, -1, 7000, 0, 1000, 11);
        chk("j6_cnt_before_rst", 128'(rec_cnt[10]), 128'(2));
        chk("j6_en_before_rst", 128'(rec_en[10]), 128'(0));
        i_mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        chk("midrst_en_held", 128'(w_output_en), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Job 7: fresh job after reset writes only its own rows.
        run_job(8'h30, 2, 2, 1, -1, 5000, 1000, 0, 13);
        for (int c = 0; c < 13; c++) begin
            chk($sformatf("j7_en_c%0d", c), 128'(rec_en[c]), 128'(c >= 9 && c <= 10));
            chk($sformatf("j7_done_c%0d", c), 128'(rec_done[c]), 128'(c >= 11));
            if (c >= 9 && c <= 10) begin
                chk($sformatf("j7_addr_c%0d", c), 128'(rec_addr[c]), 128'(8'h30 + c - 9));
                chk($sformatf("j7_data_c%0d", c), rec_data[c], row_val(5000, c - 9));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
